pipeline_controller: RTL and testbench
======================================

Name: pipeline_controller

Overview:
- Central sequencer for the five-stage pipeline (IF, ID, EX, MEM, WB). It sits beside the instruction-decode stage.
- Generates every pipeline-register write enable, the IF/ID flush and the ID/EX bubble. Handles load-use stalls, taken-branch flushes, data-memory wait freezes and the halt instruction.
- It supersedes the decode stage's local pcWrite/ifIdWrite hazard outputs and also keeps saturating stall and flush performance counters.

Parameters:
- FLUSH_CYCLES, 1, number of cycles IF/ID is flushed after a taken branch (range 1..4).
- COUNT_WIDTH, 16, width of the stallCount and flushCount counters.

Ports:
- clk  in  1  rising-edge clock
- resetN  in  1  asynchronous, active-low reset
- idRs  in  5  rs field of the instruction in ID
- idRt  in  5  rt field of the instruction in ID
- idUsesRt  in  1  the ID instruction reads rt as a source
- idExMemRead  in  1  the instruction in EX is a load
- idExRt  in  5  destination rt of the instruction in EX
- exBranchTaken  in  1  the branch in EX resolved taken
- exHalt  in  1  a halt instruction is in EX
- memBusy  in  1  data memory has not completed its access this cycle
- pcWrite  out  1  PC load enable
- ifIdWrite  out  1  IF/ID register enable
- ifIdFlush  out  1  IF/ID loads a NOP
- idExBubble  out  1  ID/EX control fields forced to zero
- idExWrite  out  1  ID/EX register enable
- exMemWrite  out  1  EX/MEM register enable
- memWbWrite  out  1  MEM/WB register enable
- halted  out  1  processor halted
- stallCount  out  COUNT_WIDTH  stall cycles since reset
- flushCount  out  COUNT_WIDTH  flush cycles since reset

Behaviour:
- Only the state, the flush counter and the perf counters are registered. All control outputs are combinational from state and inputs, so stalls take effect in the same cycle.
- States: START, RUN, FLUSH, HALTED.
- resetN=0 at any time (including mid-flush or while halted): state becomes START, flush counter 0, stallCount=0, flushCount=0.
- START outputs: all write enables 0, ifIdFlush=0, idExBubble=0, halted=0. START always goes to RUN on the next clock edge.
- memBusy=1 in RUN or FLUSH (highest priority):
  - Outputs: all five write enables 0, ifIdFlush=0, idExBubble=0.
  - State, flush counter and any pending event are held; exHalt, exBranchTaken and the load-use condition are ignored this cycle.
  - stallCount increments.
- RUN priority, below memBusy:
  1. exHalt: pcWrite=0, ifIdWrite=0, idExBubble=1, idExWrite/exMemWrite/memWbWrite=1. Next state HALTED.
  2. exBranchTaken: all writes 1, ifIdFlush=1, idExBubble=1, flushCount increments. If FLUSH_CYCLES>1, next state FLUSH with counter = FLUSH_CYCLES-1; otherwise stay in RUN.
  3. Load-use hazard, defined as idExMemRead && idExRt!=0 && (idExRt==idRs || (idUsesRt && idExRt==idRt)): pcWrite=0, ifIdWrite=0, idExBubble=1, remaining writes 1, stallCount increments. The condition clears naturally on the next cycle.
  4. Otherwise: all writes 1, ifIdFlush=0, idExBubble=0.
- FLUSH:
  - Outputs: all writes 1, ifIdFlush=1, idExBubble=1, flushCount increments, counter decrements.
  - Returns to RUN when the counter reaches 0.
  - exBranchTaken, exHalt and load-use are ignored, since the EX stage holds a bubble.
- HALTED:
  - Outputs: pcWrite=0, ifIdWrite=0, idExBubble=1, idExWrite/exMemWrite/memWbWrite=1 so older instructions drain, halted=1.
  - memBusy still freezes the pipeline. Counters do not change.
  - HALTED is left only through reset.
- Counters saturate at all-ones and never wrap.
- A zero register index (rt or rs = 0) never causes a stall.

Decomposition:
- Shared package pipeline_ctrl_pkg holds:
  - the ctrl_state_t enum (START, RUN, FLUSH, HALTED);
  - REG_ZERO = 5'd0;
  - the default FLUSH_CYCLES.
- One combinational sub-module, load_use_detect, produces the hazard flag from idRs, idRt, idUsesRt, idExMemRead and idExRt.

Test Plan:
- Reset: hold resetN=0 for 3 cycles, then release. Required: all enables 0 while in reset and during the first cycle after release (START), all enables 1 in the following cycle, both counters 0.
- Load-use: idExMemRead=1, idExRt=5, idRs=5 for 1 cycle. Required: pcWrite=0, ifIdWrite=0, idExBubble=1, stallCount=1. Repeat with idExRt=0: no stall.
- Branch: exBranchTaken=1 with FLUSH_CYCLES=2. Required: ifIdFlush=1 for 2 consecutive cycles, flushCount=2, back to RUN. A load-use condition applied during the second cycle is ignored.
- Memory wait: memBusy=1 for 4 cycles while exBranchTaken=1. Required: all writes 0 for 4 cycles, stallCount=4, then the flush occurs on the 5th cycle.
- Halt: exHalt=1. Required: HALTED next cycle with halted=1, pcWrite=0, memWbWrite=1. Then assert resetN=0 mid-halt: START, halted=0.
- Saturation: with COUNT_WIDTH=4, hold a load-use stall for 20 cycles. Required: stallCount stops at 15.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline controller.
//   ctrl_state_t         : sequencer states
//   REG_ZERO             : hard-wired zero register index, never a hazard source
//   DEFAULT_FLUSH_CYCLES : default IF/ID flush length after a taken branch
//   FLUSH_CNT_W          : width of the remaining-flush counter (FLUSH_CYCLES <= 4)
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      START  = 2'd0,
      RUN    = 2'd1,
      FLUSH  = 2'd2,
      HALTED = 2'd3
   } ctrl_state_t;

   localparam logic [4:0] REG_ZERO             = 5'd0;
   localparam int         DEFAULT_FLUSH_CYCLES = 1;
   localparam int         FLUSH_CNT_W          = 2;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector (purely combinational).
// Ports:
//   idRs_i, idRt_i     : source register fields of the instruction in ID
//   idUsesRt_i         : the ID instruction reads rt as a source
//   idExMemRead_i      : the instruction in EX is a load
//   idExRt_i           : destination of that load
//   hazard_o           : ID must stall one cycle for the load result
module load_use_detect
   import pipeline_ctrl_pkg::*;
(
   input  logic [4:0] idRs_i,
   input  logic [4:0] idRt_i,
   input  logic       idUsesRt_i,
   input  logic       idExMemRead_i,
   input  logic [4:0] idExRt_i,
   output logic       hazard_o
);

   logic rs_match;
   logic rt_match;

   assign rs_match = (idExRt_i == idRs_i);
   assign rt_match = idUsesRt_i && (idExRt_i == idRt_i);

   // A load into the zero register produces no value, so it can never stall.
   assign hazard_o = idExMemRead_i && (idExRt_i != REG_ZERO) && (rs_match || rt_match);

endmodule

// File: rtl/pipeline_controller.sv
// Central sequencer for the five-stage pipeline. Produces all pipeline
// register enables, the IF/ID flush and the ID/EX bubble, and keeps
// saturating stall / flush performance counters.
// Ports:
//   clk, resetN                      : clock, asynchronous active-low reset
//   idRs, idRt, idUsesRt             : source operands of the ID instruction
//   idExMemRead, idExRt              : load in EX and its destination
//   exBranchTaken, exHalt            : branch / halt resolved in EX
//   memBusy                          : data memory still busy this cycle
//   pcWrite, ifIdWrite               : front-end enables
//   ifIdFlush, idExBubble            : NOP injection controls
//   idExWrite, exMemWrite, memWbWrite: back-end enables
//   halted                           : processor halted
//   stallCount, flushCount           : saturating performance counters
module pipeline_controller
   import pipeline_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = DEFAULT_FLUSH_CYCLES,
   parameter int COUNT_WIDTH  = 16
) (
   input  logic                   clk,
   input  logic                   resetN,
   input  logic [4:0]             idRs,
   input  logic [4:0]             idRt,
   input  logic                   idUsesRt,
   input  logic                   idExMemRead,
   input  logic [4:0]             idExRt,
   input  logic                   exBranchTaken,
   input  logic                   exHalt,
   input  logic                   memBusy,
   output logic                   pcWrite,
   output logic                   ifIdWrite,
   output logic                   ifIdFlush,
   output logic                   idExBubble,
   output logic                   idExWrite,
   output logic                   exMemWrite,
   output logic                   memWbWrite,
   output logic                   halted,
   output logic [COUNT_WIDTH-1:0] stallCount,
   output logic [COUNT_WIDTH-1:0] flushCount
);

   localparam logic [FLUSH_CNT_W-1:0] FLUSH_INIT = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
   localparam logic [COUNT_WIDTH-1:0] CNT_ONE    = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

   function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
      return (&v) ? v : v + CNT_ONE;
   endfunction

   ctrl_state_t             state_q, state_d;
   logic [FLUSH_CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
   logic [COUNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
   logic [COUNT_WIDTH-1:0]  flush_tot_q, flush_tot_d;

   logic load_use;
   logic front_wr;   // pcWrite / ifIdWrite
   logic back_wr;    // idExWrite / exMemWrite / memWbWrite
   logic stall_inc;
   logic flush_inc;

   load_use_detect u_load_use (
      .idRs_i        (idRs),
      .idRt_i        (idRt),
      .idUsesRt_i    (idUsesRt),
      .idExMemRead_i (idExMemRead),
      .idExRt_i      (idExRt),
      .hazard_o      (load_use)
   );

   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      front_wr    = 1'b0;
      back_wr     = 1'b0;
      ifIdFlush   = 1'b0;
      idExBubble  = 1'b0;
      halted      = 1'b0;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;

      unique case (state_q)
         START: begin
            state_d = RUN;
         end

         RUN: begin
            // A busy memory freezes everything and masks every EX/ID event;
            // they are re-evaluated once the access completes.
            if (memBusy) begin
               stall_inc = 1'b1;
            end else if (exHalt) begin
               back_wr    = 1'b1;
               idExBubble = 1'b1;
               state_d    = HALTED;
            end else if (exBranchTaken) begin
               front_wr   = 1'b1;
               back_wr    = 1'b1;
               ifIdFlush  = 1'b1;
               idExBubble = 1'b1;
               flush_inc  = 1'b1;
               if (FLUSH_CYCLES > 1) begin
                  state_d     = FLUSH;
                  flush_cnt_d = FLUSH_INIT;
               end
            end else if (load_use) begin
               back_wr    = 1'b1;
               idExBubble = 1'b1;
               stall_inc  = 1'b1;
            end else begin
               front_wr = 1'b1;
               back_wr  = 1'b1;
            end
         end

         FLUSH: begin
            // EX holds a bubble here, so branch/halt/load-use cannot be real.
            if (memBusy) begin
               stall_inc = 1'b1;
            end else begin
               front_wr    = 1'b1;
               back_wr     = 1'b1;
               ifIdFlush   = 1'b1;
               idExBubble  = 1'b1;
               flush_inc   = 1'b1;
               flush_cnt_d = flush_cnt_q - 1'b1;
               if (flush_cnt_d == '0) begin
                  state_d = RUN;
               end
            end
         end

         HALTED: begin
            halted = 1'b1;
            if (!memBusy) begin
               back_wr    = 1'b1;
               idExBubble = 1'b1;
            end
         end

         default: begin
            state_d = START;
         end
      endcase

      stall_cnt_d = stall_inc ? sat_inc(stall_cnt_q) : stall_cnt_q;
      flush_tot_d = flush_inc ? sat_inc(flush_tot_q) : flush_tot_q;
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q     <= START;
         flush_cnt_q <= '0;
         stall_cnt_q <= '0;
         flush_tot_q <= '0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_tot_q <= flush_tot_d;
      end
   end

   assign pcWrite    = front_wr;
   assign ifIdWrite  = front_wr;
   assign idExWrite  = back_wr;
   assign exMemWrite = back_wr;
   assign memWbWrite = back_wr;
   assign stallCount = stall_cnt_q;
   assign flushCount = flush_tot_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Bench for pipeline_controller: two instances (FLUSH_CYCLES=2/COUNT_WIDTH=16
// and FLUSH_CYCLES=1/COUNT_WIDTH=4) driven by the same inputs, each followed
// by a behavioural model, plus directed literal checks.
module tb_pipeline_controller;

   logic       clk = 1'b0;
   logic       resetN;
   logic [4:0] idRs, idRt, idExRt;
   logic       idUsesRt, idExMemRead, exBranchTaken, exHalt, memBusy;

   logic        a_pc, a_ifw, a_iff, a_bub, a_idw, a_exw, a_mww, a_hlt;
   logic [15:0] a_stall, a_flush;
   logic        b_pc, b_ifw, b_iff, b_bub, b_idw, b_exw, b_mww, b_hlt;
   logic [3:0]  b_stall, b_flush;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipeline_controller #(.FLUSH_CYCLES(2), .COUNT_WIDTH(16)) dut_a (
      .clk(clk), .resetN(resetN), .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
      .idExMemRead(idExMemRead), .idExRt(idExRt), .exBranchTaken(exBranchTaken),
      .exHalt(exHalt), .memBusy(memBusy), .pcWrite(a_pc), .ifIdWrite(a_ifw),
      .ifIdFlush(a_iff), .idExBubble(a_bub), .idExWrite(a_idw), .exMemWrite(a_exw),
      .memWbWrite(a_mww), .halted(a_hlt), .stallCount(a_stall), .flushCount(a_flush)
   );

   pipeline_controller #(.FLUSH_CYCLES(1), .COUNT_WIDTH(4)) dut_b (
      .clk(clk), .resetN(resetN), .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
      .idExMemRead(idExMemRead), .idExRt(idExRt), .exBranchTaken(exBranchTaken),
      .exHalt(exHalt), .memBusy(memBusy), .pcWrite(b_pc), .ifIdWrite(b_ifw),
      .ifIdFlush(b_iff), .idExBubble(b_bub), .idExWrite(b_idw), .exMemWrite(b_exw),
      .memWbWrite(b_mww), .halted(b_hlt), .stallCount(b_stall), .flushCount(b_flush)
   );

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      bit started;
      bit stopped;
      int flush_left;
      int stalls;
      int flushes;
   } mdl_t;

   // Expected control vector bit order:
   // {pcWrite, ifIdWrite, ifIdFlush, idExBubble, idExWrite, exMemWrite, memWbWrite, halted}
   localparam logic [7:0] E_ALL   = 8'b1100_1110;
   localparam logic [7:0] E_BR    = 8'b1111_1110;
   localparam logic [7:0] E_STALL = 8'b0001_1110;
   localparam logic [7:0] E_HDRN  = 8'b0001_1111;
   localparam logic [7:0] E_HBSY  = 8'b0000_0001;

   function automatic mdl_t mdl_reset();
      mdl_t m;
      m.started = 0; m.stopped = 0; m.flush_left = 0; m.stalls = 0; m.flushes = 0;
      return m;
   endfunction

   function automatic int sat(input int v, input int maxc);
      return (v >= maxc) ? maxc : v + 1;
   endfunction

   function automatic void mstep(input mdl_t m, input int fc, input int maxc,
                                 output logic [7:0] e, output mdl_t n);
      bit lu;
      lu = idExMemRead && (idExRt != 0) &&
           ((idExRt == idRs) || (idUsesRt && (idExRt == idRt)));
      n = m;
      e = 8'h00;
      if (!m.started) begin
         n.started = 1;
      end else if (m.stopped) begin
         e = memBusy ? E_HBSY : E_HDRN;
      end else if (memBusy) begin
         n.stalls = sat(m.stalls, maxc);
      end else if (m.flush_left > 0) begin
         e = E_BR;
         n.flushes = sat(m.flushes, maxc);
         n.flush_left = m.flush_left - 1;
      end else if (exHalt) begin
         e = E_STALL;
         n.stopped = 1;
      end else if (exBranchTaken) begin
         e = E_BR;
         n.flushes = sat(m.flushes, maxc);
         n.flush_left = fc - 1;
      end else if (lu) begin
         e = E_STALL;
         n.stalls = sat(m.stalls, maxc);
      end else begin
         e = E_ALL;
      end
   endfunction

   mdl_t ma, mb, na, nb;
   initial begin
      ma = mdl_reset(); mb = mdl_reset(); na = mdl_reset(); nb = mdl_reset();
   end

   always @(negedge clk) begin
      logic [7:0] ea, eb;
      if (!resetN) begin
         ma = mdl_reset(); mb = mdl_reset();
      end
      if (!resetN) begin
         ea = 8'h00; eb = 8'h00; na = ma; nb = mb;
      end else begin
         mstep(ma, 2, 65535, ea, na);
         mstep(mb, 1, 15, eb, nb);
      end
      chk("model_ctl_a", {a_pc, a_ifw, a_iff, a_bub, a_idw, a_exw, a_mww, a_hlt}, ea);
      chk("model_stall_a", a_stall, ma.stalls);
      chk("model_flush_a", a_flush, ma.flushes);
      chk("model_ctl_b", {b_pc, b_ifw, b_iff, b_bub, b_idw, b_exw, b_mww, b_hlt}, eb);
      chk("model_stall_b", b_stall, mb.stalls);
      chk("model_flush_b", b_flush, mb.flushes);
   end

   always @(posedge clk) begin
      if (resetN) begin
         ma = na; mb = nb;
      end else begin
         ma = mdl_reset(); mb = mdl_reset();
      end
   end

   // ---------------- stimulus ----------------
   task automatic nxt();
      @(posedge clk); #1;
   endtask

   task automatic mid();
      @(negedge clk); #1;
   endtask

   task automatic idle();
      idRs = 0; idRt = 0; idExRt = 0; idUsesRt = 0; idExMemRead = 0;
      exBranchTaken = 0; exHalt = 0; memBusy = 0;
   endtask

   task automatic set_lu();
      idExMemRead = 1; idExRt = 5'd5; idRs = 5'd5;
   endtask

   initial begin
      resetN = 1'b0;
      idle();
      repeat (3) @(posedge clk);
      mid();
      chk("rst_pcWrite", a_pc, 0);
      chk("rst_memWbWrite", a_mww, 0);
      nxt(); resetN = 1'b1;
      mid();
      chk("start_pcWrite", a_pc, 0);
      chk("start_memWbWrite", a_mww, 0);
      nxt(); mid();
      chk("run_pcWrite", a_pc, 1);
      chk("run_memWbWrite", a_mww, 1);
      chk("run_stall0", a_stall, 0);
      chk("run_flush0", a_flush, 0);

      // load-use stall, then zero-register load
      nxt(); set_lu(); mid();
      chk("lu_pcWrite", a_pc, 0);
      chk("lu_ifIdWrite", a_ifw, 0);
      chk("lu_bubble", a_bub, 1);
      nxt(); idle(); mid();
      chk("lu_stallCount", a_stall, 1);
      nxt(); idExMemRead = 1; idExRt = 0; idRs = 0; mid();
      chk("lu_zero_pcWrite", a_pc, 1);
      nxt(); idle(); mid();
      chk("lu_zero_stallCount", a_stall, 1);

      // taken branch, FLUSH_CYCLES=2; load-use in second cycle ignored
      nxt(); exBranchTaken = 1; mid();
      chk("br_flush1", a_iff, 1);
      nxt(); idle(); set_lu(); mid();
      chk("br_flush2", a_iff, 1);
      chk("br_lu_ignored_pc", a_pc, 1);
      nxt(); idle(); mid();
      chk("br_done_flush", a_iff, 0);
      chk("br_flushCount", a_flush, 2);
      chk("br_stallCount", a_stall, 1);

      // memory wait masks a pending branch for 4 cycles
      for (int i = 0; i < 4; i++) begin
         nxt(); memBusy = 1; exBranchTaken = 1; mid();
         chk("mw_pcWrite", a_pc, 0);
         chk("mw_memWbWrite", a_mww, 0);
         chk("mw_ifIdFlush", a_iff, 0);
      end
      nxt(); memBusy = 0; mid();
      chk("mw_flush_after", a_iff, 1);
      chk("mw_stallCount", a_stall, 5);
      nxt(); idle(); mid();
      chk("mw_flush_second", a_iff, 1);
      nxt(); mid();
      chk("mw_flushCount", a_flush, 4);

      // halt
      nxt(); exHalt = 1; mid();
      chk("halt_ex_pc", a_pc, 0);
      chk("halt_ex_bubble", a_bub, 1);
      nxt(); exHalt = 0; exBranchTaken = 1; mid();
      chk("halted", a_hlt, 1);
      chk("halted_pcWrite", a_pc, 0);
      chk("halted_memWbWrite", a_mww, 1);
      nxt(); idle(); mid();
      chk("halted_flushCount", a_flush, 4);
      nxt(); resetN = 0; mid();
      chk("halt_rst_halted", a_hlt, 0);
      chk("halt_rst_pc", a_pc, 0);
      chk("halt_rst_stall", a_stall, 0);
      nxt(); resetN = 1;
      nxt(); nxt();

      // saturation on the 4-bit instance
      nxt(); set_lu();
      repeat (19) nxt();
      nxt(); idle(); mid();
      chk("sat_stall_b", b_stall, 15);
      chk("sat_stall_a", a_stall, 20);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         nxt();
         resetN        = ($urandom_range(0, 199) != 0);
         memBusy       = ($urandom_range(0, 4) == 0);
         exBranchTaken = ($urandom_range(0, 7) == 0);
         exHalt        = ($urandom_range(0, 59) == 0);
         idExMemRead   = $urandom_range(0, 1);
         idUsesRt      = $urandom_range(0, 1);
         idExRt        = 5'($urandom_range(0, 3));
         idRs          = 5'($urandom_range(0, 3));
         idRt          = 5'($urandom_range(0, 3));
      end
      nxt(); idle(); resetN = 1;
      mid();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
